// File: rtl/n_term_reflect_probe_if.sv
// Snapshot probe port of the north-edge terminator: capture request, a
// valid/ready chunk stream and the probe status flags.
interface n_term_reflect_probe_if #(
   parameter int WORD_W = 8
);
   logic              probe_req;
   logic              probe_busy;
   logic              probe_valid;
   logic              probe_ready;
   logic [WORD_W-1:0] probe_dout;
   logic              probe_last;
   logic              probe_ovf;

   modport master (
      output probe_req, probe_ready,
      input  probe_busy, probe_valid, probe_dout, probe_last, probe_ovf
   );

   modport slave (
      input  probe_req, probe_ready,
      output probe_busy, probe_valid, probe_dout, probe_last, probe_ovf
   );
endinterface

// File: rtl/n_term_reflect_probe.sv
// North-edge terminator: reflects N*END wires back south with index reversal, plus a
// snapshot probe and activity counter. Define REFLECT_REG_EN to register the S*BEG outputs.
module n_term_reflect_probe #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                 UserCLK,
   input  logic                 reset,
   input  logic [3:0]           N1END,
   input  logic [7:0]           N2MID,
   input  logic [7:0]           N2END,
   input  logic [15:0]          N4END,
   output logic [3:0]           S1BEG,
   output logic [7:0]           S2BEG,
   output logic [7:0]           S2BEGb,
   output logic [15:0]          S4BEG,
   n_term_reflect_probe_if.slave probe,
   output logic [CNT_W-1:0]     act_count
);
   localparam int NCH   = (36 + WORD_W - 1) / WORD_W;
   localparam int PAD_W = NCH * WORD_W;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [35:0]        wires;
   logic [35:0]        sample;
   logic [35:0]        prev;
   logic [PAD_W-1:0]   snap;
   logic               accept;
   logic [3:0]         s1_rev;
   logic [7:0]         s2_rev;
   logic [7:0]         s2b_rev;
   logic [15:0]        s4_rev;

   assign wires  = {N4END, N2END, N2MID, N1END};
   assign accept = (state == IDLE) && probe.probe_req;

   always_comb begin
      s1_rev  = '0;
      s2_rev  = '0;
      s2b_rev = '0;
      s4_rev  = '0;
      for (int i = 0; i < 4; i++)  s1_rev[i]  = N1END[3 - i];
      for (int i = 0; i < 8; i++)  s2_rev[i]  = N2MID[7 - i];
      for (int i = 0; i < 8; i++)  s2b_rev[i] = N2END[7 - i];
      for (int i = 0; i < 16; i++) s4_rev[i]  = N4END[15 - i];
   end

`ifdef REFLECT_REG_EN
   always_ff @(posedge UserCLK) begin
      if (reset) begin
         S1BEG  <= '0;
         S2BEG  <= '0;
         S2BEGb <= '0;
         S4BEG  <= '0;
      end else begin
         S1BEG  <= s1_rev;
         S2BEG  <= s2_rev;
         S2BEGb <= s2b_rev;
         S4BEG  <= s4_rev;
      end
   end
`else
   assign S1BEG  = s1_rev;
   assign S2BEG  = s2_rev;
   assign S2BEGb = s2b_rev;
   assign S4BEG  = s4_rev;
`endif

   // A capture request clears the count, overriding any increment in the same cycle.
   always_ff @(posedge UserCLK) begin
      if (reset) begin
         sample    <= '0;
         prev      <= '0;
         act_count <= '0;
      end else begin
         sample <= wires;
         prev   <= sample;
         if (accept) begin
            act_count <= '0;
         end else if ((sample != prev) && (act_count != {CNT_W{1'b1}})) begin
            act_count <= act_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         state           <= IDLE;
         idx             <= '0;
         snap            <= '0;
         probe.probe_ovf <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (accept) begin
            snap <= PAD_W'(wires);
         end
         if (probe.probe_req && (state != IDLE)) begin
            probe.probe_ovf <= 1'b1;
         end
      end
   end

   // Snapshot is zero-padded to whole chunks, so bits above 35 read back as 0.
   always_comb begin
      state_nxt         = state;
      idx_nxt           = idx;
      probe.probe_busy  = 1'b0;
      probe.probe_valid = 1'b0;
      probe.probe_last  = 1'b0;
      probe.probe_dout  = '0;
      case (state)
         IDLE: begin
            if (probe.probe_req) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            probe.probe_busy = 1'b1;
            idx_nxt          = '0;
            state_nxt        = SHIFT;
         end
         SHIFT: begin
            probe.probe_busy  = 1'b1;
            probe.probe_valid = 1'b1;
            probe.probe_last  = (idx == LAST_IDX);
            probe.probe_dout  = snap[int'(idx) * WORD_W +: WORD_W];
            if (probe.probe_ready) begin
               if (idx == LAST_IDX) begin
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_n_term_reflect_probe.sv
// Self-checking bench for n_term_reflect_probe: reflection, snapshot streaming,
// backpressure, overflow, activity counting and reset mid-stream.
module tb_n_term_reflect_probe;
   localparam int W    = 8;
   localparam int NCH  = 5;
   localparam int W2   = 5;
   localparam int NCH2 = 8;

   logic        UserCLK = 1'b0;
   logic        reset;
   logic [35:0] vin;
   logic [3:0]  S1BEG, s1beg2;
   logic [7:0]  S2BEG, S2BEGb, s2beg2, s2begb2;
   logic [15:0] S4BEG, s4beg2;
   logic [15:0] act_count;
   logic [1:0]  act_count2;

   int          checks = 0;
   int          errors = 0;
   int          model_changes = 0;
   logic [35:0] model_last = '0;
   int          base_main = 0;
   int          base2 = 0;
   logic        exp_ovf = 1'b0;

   n_term_reflect_probe_if #(.WORD_W(W))  pif ();
   n_term_reflect_probe_if #(.WORD_W(W2)) pif2 ();

   n_term_reflect_probe #(.WORD_W(W), .CNT_W(16)) dut (
      .UserCLK(UserCLK), .reset(reset),
      .N1END(vin[3:0]), .N2MID(vin[11:4]), .N2END(vin[19:12]), .N4END(vin[35:20]),
      .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG),
      .probe(pif), .act_count(act_count)
   );

   n_term_reflect_probe #(.WORD_W(W2), .CNT_W(2)) dut2 (
      .UserCLK(UserCLK), .reset(reset),
      .N1END(vin[3:0]), .N2MID(vin[11:4]), .N2END(vin[19:12]), .N4END(vin[35:20]),
      .S1BEG(s1beg2), .S2BEG(s2beg2), .S2BEGb(s2begb2), .S4BEG(s4beg2),
      .probe(pif2), .act_count(act_count2)
   );

   always #5 UserCLK = ~UserCLK;

   // Counts every change of the sampled wire vector since the last reset.
   always @(posedge UserCLK) begin
      if (reset) begin
         model_changes = 0;
         model_last    = '0;
      end else if (vin !== model_last) begin
         model_changes = model_changes + 1;
         model_last    = vin;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [35:0] reflect_model(input logic [35:0] v);
      logic [35:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)  r[i]      = v[3 - i];
      for (int i = 0; i < 8; i++)  r[4 + i]  = v[4 + 7 - i];
      for (int i = 0; i < 8; i++)  r[12 + i] = v[12 + 7 - i];
      for (int i = 0; i < 16; i++) r[20 + i] = v[20 + 15 - i];
      return r;
   endfunction

   function automatic logic [35:0] rand36();
      return {4'($urandom), 32'($urandom)};
   endfunction

   function automatic int sat(input int d, input int mx);
      return (d > mx) ? mx : d;
   endfunction

   task automatic test_reset();
      logic [35:0] exp_refl;
      vin   = rand36();
      reset = 1'b1;
      repeat (2) @(negedge UserCLK);
      checks++;
      if ({pif.probe_valid, pif.probe_busy, pif.probe_last, pif.probe_ovf} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got v/b/l/o=%b%b%b%b expected 0000",
                  pif.probe_valid, pif.probe_busy, pif.probe_last, pif.probe_ovf);
      end
      checks++;
      if (pif.probe_dout !== 8'h00 || act_count !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_data: got dout=%h act=%0d expected 0/0",
                  pif.probe_dout, act_count);
      end
`ifdef REFLECT_REG_EN
      exp_refl = '0;
`else
      exp_refl = reflect_model(vin);
`endif
      checks++;
      if ({S4BEG, S2BEGb, S2BEG, S1BEG} !== exp_refl) begin
         errors++;
         $display("[TB] FAIL reset_reflect: got %h expected %h",
                  {S4BEG, S2BEGb, S2BEG, S1BEG}, exp_refl);
      end
      reset     = 1'b0;
      base_main = 0;
      base2     = 0;
      exp_ovf   = 1'b0;
      @(negedge UserCLK);
   endtask

   task automatic test_reflect();
      logic [35:0] v;
      logic [35:0] exp_refl;
      for (int n = 0; n < 10; n++) begin
         v = (n == 0) ? {16'h0001, 8'h00, 8'h00, 4'b0001} : rand36();
         vin = v;
         exp_refl = reflect_model(v);
`ifdef REFLECT_REG_EN
         @(posedge UserCLK);
         #1;
`else
         #1;
`endif
         if (n == 0) begin
            checks++;
            if (S4BEG !== 16'h8000 || S1BEG !== 4'b1000) begin
               errors++;
               $display("[TB] FAIL reflect_directed: got S4=%h S1=%b expected 8000/1000",
                        S4BEG, S1BEG);
            end
         end
         checks++;
         if ({S4BEG, S2BEGb, S2BEG, S1BEG} !== exp_refl ||
             {s4beg2, s2begb2, s2beg2, s1beg2} !== exp_refl) begin
            errors++;
            $display("[TB] FAIL reflect: got %h / %h expected %h",
                     {S4BEG, S2BEGb, S2BEG, S1BEG}, {s4beg2, s2begb2, s2beg2, s1beg2}, exp_refl);
         end
         @(negedge UserCLK);
      end
   endtask

   task automatic run_stream(input logic [35:0] v, input int stall_chunk, input int stall_len,
                             input bit rand_ready, input int req_chunk, input int reset_chunk,
                             output int ncycles);
      int idx;
      int stalls;
      bit req_done;
      bit rdy;
      logic [7:0] exp;
      vin = v;
      repeat (3) @(negedge UserCLK);
      pif.probe_req   = 1'b1;
      pif.probe_ready = 1'b0;
      @(negedge UserCLK);
      pif.probe_req = 1'b0;
      base_main     = model_changes;
      checks++;
      if (pif.probe_busy !== 1'b1 || pif.probe_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL capture: got busy=%b valid=%b expected 1/0",
                  pif.probe_busy, pif.probe_valid);
      end
      checks++;
      if (act_count !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL act_clear: got %0d expected 0", act_count);
      end
      @(negedge UserCLK);
      idx      = 0;
      ncycles  = 0;
      stalls   = 0;
      req_done = 0;
      while (idx < NCH && ncycles < 200) begin
         exp = 8'(64'(v) >> (idx * W));
         checks++;
         if (pif.probe_valid !== 1'b1 || pif.probe_dout !== exp ||
             pif.probe_last !== (idx == NCH - 1)) begin
            errors++;
            $display("[TB] FAIL chunk%0d: got valid=%b dout=%h last=%b expected 1/%h/%b",
                     idx, pif.probe_valid, pif.probe_dout, pif.probe_last, exp, idx == NCH - 1);
         end
         if (idx == reset_chunk) begin
            reset = 1'b1;
            @(negedge UserCLK);
            checks++;
            if ({pif.probe_valid, pif.probe_busy, pif.probe_ovf, pif.probe_last} !== 4'b0000 ||
                act_count !== 16'h0000 || pif.probe_dout !== 8'h00) begin
               errors++;
               $display("[TB] FAIL reset_mid_shift: got v/b/o/l=%b%b%b%b act=%0d dout=%h expected 0",
                        pif.probe_valid, pif.probe_busy, pif.probe_ovf, pif.probe_last,
                        act_count, pif.probe_dout);
            end
            reset           = 1'b0;
            base_main       = 0;
            base2           = 0;
            exp_ovf         = 1'b0;
            pif.probe_req   = 1'b0;
            pif.probe_ready = 1'b0;
            return;
         end
         if (idx == stall_chunk && stalls < stall_len) begin
            rdy = 1'b0;
            stalls++;
         end else if (rand_ready) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         pif.probe_ready = rdy;
         if (idx == req_chunk && !req_done) begin
            pif.probe_req = 1'b1;
            req_done      = 1;
            exp_ovf       = 1'b1;
         end else begin
            pif.probe_req = 1'b0;
         end
         @(posedge UserCLK);
         if (rdy) idx++;
         ncycles++;
         @(negedge UserCLK);
      end
      pif.probe_req   = 1'b0;
      pif.probe_ready = 1'b0;
      if (idx < NCH) begin
         checks++;
         errors++;
         $display("[TB] FAIL stream_timeout: got %0d chunks expected %0d", idx, NCH);
      end
      checks++;
      if (pif.probe_busy !== 1'b0 || pif.probe_valid !== 1'b0 || pif.probe_ovf !== exp_ovf) begin
         errors++;
         $display("[TB] FAIL stream_end: got busy=%b valid=%b ovf=%b expected 0/0/%b",
                  pif.probe_busy, pif.probe_valid, pif.probe_ovf, exp_ovf);
      end
   endtask

   task automatic test_snapshot();
      int nc;
      run_stream(36'hA_BCDE_F012, -1, 0, 1'b0, -1, -1, nc);
      checks++;
      if (nc !== NCH) begin
         errors++;
         $display("[TB] FAIL throughput: got %0d cycles expected %0d", nc, NCH);
      end
      for (int n = 0; n < 3; n++) begin
         run_stream(rand36(), -1, 0, 1'b1, -1, -1, nc);
      end
   endtask

   task automatic test_backpressure();
      int nc;
      run_stream(36'hA_BCDE_F012, 2, 3, 1'b0, -1, -1, nc);
      checks++;
      if (nc !== NCH + 3) begin
         errors++;
         $display("[TB] FAIL backpressure_cycles: got %0d expected %0d", nc, NCH + 3);
      end
   endtask

   task automatic test_overflow();
      int nc;
      run_stream(rand36(), -1, 0, 1'b0, 1, -1, nc);
      run_stream(rand36(), -1, 0, 1'b1, -1, -1, nc);
      run_stream(rand36(), -1, 0, 1'b0, NCH - 1, -1, nc);
   endtask

   task automatic check_activity(input string name);
      checks++;
      if (act_count !== 16'(sat(model_changes - base_main, 65535))) begin
         errors++;
         $display("[TB] FAIL %s_main: got %0d expected %0d", name, act_count,
                  sat(model_changes - base_main, 65535));
      end
      checks++;
      if (act_count2 !== 2'(sat(model_changes - base2, 3))) begin
         errors++;
         $display("[TB] FAIL %s_sat: got %0d expected %0d", name, act_count2,
                  sat(model_changes - base2, 3));
      end
   endtask

   task automatic test_activity();
      int nc;
      vin   = '0;
      reset = 1'b1;
      @(negedge UserCLK);
      reset     = 1'b0;
      base_main = 0;
      base2     = 0;
      exp_ovf   = 1'b0;
      repeat (3) @(negedge UserCLK);
      for (int n = 0; n < 5; n++) begin
         vin[4] = 1'b1;
         @(negedge UserCLK);
         vin[4] = 1'b0;
         @(negedge UserCLK);
      end
      repeat (3) @(negedge UserCLK);
      check_activity("act_pulses");
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 1) == 1) vin = rand36();
         @(negedge UserCLK);
      end
      repeat (3) @(negedge UserCLK);
      check_activity("act_random");
      run_stream(vin, -1, 0, 1'b0, -1, -1, nc);
      repeat (3) @(negedge UserCLK);
      check_activity("act_after_req");
   endtask

   task automatic test_narrow_word();
      logic [35:0] v;
      logic [4:0]  exp;
      v   = rand36() | 36'h8_0000_0000;
      vin = v;
      repeat (3) @(negedge UserCLK);
      pif2.probe_req   = 1'b1;
      pif2.probe_ready = 1'b1;
      @(negedge UserCLK);
      pif2.probe_req = 1'b0;
      base2          = model_changes;
      checks++;
      if (pif2.probe_busy !== 1'b1 || act_count2 !== 2'd0) begin
         errors++;
         $display("[TB] FAIL narrow_capture: got busy=%b act=%0d expected 1/0",
                  pif2.probe_busy, act_count2);
      end
      @(negedge UserCLK);
      for (int i = 0; i < NCH2; i++) begin
         exp = 5'(64'(v) >> (i * W2));
         checks++;
         if (pif2.probe_valid !== 1'b1 || pif2.probe_dout !== exp ||
             pif2.probe_last !== (i == NCH2 - 1)) begin
            errors++;
            $display("[TB] FAIL narrow_chunk%0d: got valid=%b dout=%h last=%b expected 1/%h/%b",
                     i, pif2.probe_valid, pif2.probe_dout, pif2.probe_last, exp, i == NCH2 - 1);
         end
         @(negedge UserCLK);
      end
      pif2.probe_ready = 1'b0;
      checks++;
      if (pif2.probe_busy !== 1'b0 || pif2.probe_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL narrow_end: got busy=%b ovf=%b expected 0/0",
                  pif2.probe_busy, pif2.probe_ovf);
      end
   endtask

   task automatic test_reset_mid_shift();
      int nc;
      run_stream(rand36(), -1, 0, 1'b0, 1, 3, nc);
      run_stream(rand36(), -1, 0, 1'b0, -1, -1, nc);
   endtask

   initial begin
      vin              = '0;
      reset            = 1'b1;
      pif.probe_req    = 1'b0;
      pif.probe_ready  = 1'b0;
      pif2.probe_req   = 1'b0;
      pif2.probe_ready = 1'b0;
      test_reset();
      test_reflect();
      test_snapshot();
      test_backpressure();
      test_overflow();
      test_activity();
      test_narrow_word();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
